// File: rtl/seven_segment_scanner_pkg.sv
// -----------------------------------------------------------------------------
// seven_segment_scanner_pkg
// Shared display definitions: segment bit positions, the standard hex-to-
// segment decode table (active-high, bit0 = a ... bit6 = g) and a decode
// helper, for use by any block driving seven-segment displays.
// -----------------------------------------------------------------------------
package seven_segment_scanner_pkg;

   typedef logic [6:0] seg_t;

   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   // Entry [n] is the active-high pattern for hex digit n (leftmost is F).
   localparam logic [15:0][6:0] HEX_SEG_LUT = {
      7'h71,   // F  a e f g
      7'h79,   // E  a d e f g
      7'h5E,   // d  b c d e g
      7'h39,   // C  a d e f
      7'h7C,   // b  c d e f g
      7'h77,   // A  a b c e f g
      7'h6F,   // 9  a b c d f g
      7'h7F,   // 8  all
      7'h07,   // 7  a b c
      7'h7D,   // 6  a c d e f g
      7'h6D,   // 5  a c d f g
      7'h66,   // 4  b c f g
      7'h4F,   // 3  a b c d g
      7'h5B,   // 2  a b d e g
      7'h06,   // 1  b c
      7'h3F    // 0  a b c d e f
   };

   function automatic seg_t seg_decode(input logic [3:0] nib);
      return HEX_SEG_LUT[nib];
   endfunction

endpackage

// File: rtl/seven_segment_scanner_hex_to_seg.sv
// -----------------------------------------------------------------------------
// hex_to_seg
// Combinational hex nibble to seven-segment decoder, active-high output.
// Ports:
//   i_nibble  4-bit hex value
//   o_seg     7-bit segment pattern, bit0 = a ... bit6 = g, 1 = lit
// -----------------------------------------------------------------------------
module hex_to_seg
   import seven_segment_scanner_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_seg
);

   assign o_seg = seg_decode(i_nibble);

endmodule

// File: rtl/seven_segment_scanner.sv
// -----------------------------------------------------------------------------
// seven_segment_scanner
// Time-multiplexed driver for DIGITS seven-segment digits. A prescaler holds
// each digit lit for DIV clocks, with GUARD clocks of all-anodes-off at the
// start of each slot to prevent ghosting. New values are loaded into a
// staging copy and only moved to the display copy at the frame boundary
// (last digit -> digit 0), so a frame never mixes old and new data.
// Ports:
//   CLK      system clock, rising edge
//   RST_X    asynchronous active-low reset
//   VALUE    4 bits per digit, nibble 0 = rightmost digit = anode 0
//   DP       decimal point per digit, 1 = lit
//   BLANK    per-digit blank, 1 = dark (DP included)
//   LOAD     single-cycle capture strobe for VALUE/DP/BLANK
//   PENDING  staged data waiting for the next frame boundary
//   LED_AN   anode enables
//   LED_SEG  segments a..g (bit0 = a)
//   LED_DP   decimal point
// Outputs are active-low when ACTIVE_LOW = 1; all internal logic is
// active-high.
// -----------------------------------------------------------------------------
module seven_segment_scanner
   import seven_segment_scanner_pkg::*;
#(
   parameter int DIGITS     = 4,
   parameter int DIV        = 50000,
   parameter int GUARD      = 16,
   parameter int ACTIVE_LOW = 1
)
(
   input  logic                  CLK,
   input  logic                  RST_X,
   input  logic [4*DIGITS-1:0]   VALUE,
   input  logic [DIGITS-1:0]     DP,
   input  logic [DIGITS-1:0]     BLANK,
   input  logic                  LOAD,
   output logic                  PENDING,
   output logic [DIGITS-1:0]     LED_AN,
   output logic [6:0]            LED_SEG,
   output logic                  LED_DP
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   // scan timing
   logic [PW-1:0]         r_presc;
   logic [IW-1:0]         r_idx;
   logic                  w_presc_wrap;
   logic                  w_frame_wrap;
   logic                  w_guard;

   // staging and display copies
   logic [4*DIGITS-1:0]   r_stg_value;
   logic [DIGITS-1:0]     r_stg_dp;
   logic [DIGITS-1:0]     r_stg_blank;
   logic [4*DIGITS-1:0]   r_disp_value;
   logic [DIGITS-1:0]     r_disp_dp;
   logic [DIGITS-1:0]     r_disp_blank;
   logic                  r_pending;
   logic                  r_live;

   // current-digit selection
   logic [3:0]            w_cur_nib;
   logic                  w_cur_dp;
   logic                  w_cur_blank;
   logic [6:0]            w_dec_seg;
   logic [DIGITS-1:0]     w_an_next;
   logic [6:0]            w_seg_next;
   logic                  w_dp_next;

   // output registers (active-high)
   logic [DIGITS-1:0]     r_an;
   logic [6:0]            r_seg;
   logic                  r_dp;

   assign w_presc_wrap = (r_presc == PW'(DIV - 1));
   assign w_frame_wrap = w_presc_wrap && (r_idx == IW'(DIGITS - 1));
   assign w_guard      = (r_presc < PW'(GUARD));

   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         r_presc <= '0;
         r_idx   <= '0;
      end else if (w_presc_wrap) begin
         r_presc <= '0;
         r_idx   <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
      end else begin
         r_presc <= r_presc + PW'(1);
      end
   end

   // LOAD always overwrites staging; a LOAD on the transfer cycle still lets
   // the previous staging contents move to the display (old values sampled).
   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         r_stg_value  <= '0;
         r_stg_dp     <= '0;
         r_stg_blank  <= '1;
         r_disp_value <= '0;
         r_disp_dp    <= '0;
         r_disp_blank <= '1;
         r_pending    <= 1'b0;
         r_live       <= 1'b0;
      end else begin
         if (LOAD) begin
            r_stg_value <= VALUE;
            r_stg_dp    <= DP;
            r_stg_blank <= BLANK;
         end
         if (w_frame_wrap && r_pending) begin
            r_disp_value <= r_stg_value;
            r_disp_dp    <= r_stg_dp;
            r_disp_blank <= r_stg_blank;
            r_live       <= 1'b1;
         end
         if (LOAD)
            r_pending <= 1'b1;
         else if (w_frame_wrap)
            r_pending <= 1'b0;
      end
   end

   // Anodes stay dark until the first real transfer after reset.
   always_comb begin
      w_cur_nib   = '0;
      w_cur_dp    = 1'b0;
      w_cur_blank = 1'b1;
      w_an_next   = '0;
      for (int d = 0; d < DIGITS; d++) begin
         if (r_idx == IW'(d)) begin
            w_cur_nib    = r_disp_value[4*d +: 4];
            w_cur_dp     = r_disp_dp[d];
            w_cur_blank  = r_disp_blank[d];
            w_an_next[d] = r_live && !w_guard;
         end
      end
   end

   hex_to_seg u_hex_to_seg (
      .i_nibble (w_cur_nib),
      .o_seg    (w_dec_seg)
   );

   assign w_seg_next = (w_cur_blank || !r_live) ? 7'h00 : w_dec_seg;
   assign w_dp_next  = w_cur_dp && !w_cur_blank && r_live;

   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         r_an  <= '0;
         r_seg <= '0;
         r_dp  <= 1'b0;
      end else begin
         r_an  <= w_an_next;
         r_seg <= w_seg_next;
         r_dp  <= w_dp_next;
      end
   end

   // Polarity is applied only at the pins.
   assign LED_AN  = (ACTIVE_LOW != 0) ? ~r_an  : r_an;
   assign LED_SEG = (ACTIVE_LOW != 0) ? ~r_seg : r_seg;
   assign LED_DP  = (ACTIVE_LOW != 0) ? ~r_dp  : r_dp;
   assign PENDING = r_pending;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// -----------------------------------------------------------------------------
// tb_seven_segment_scanner
// Directed bench for seven_segment_scanner with DIGITS=4, DIV=8, GUARD=2,
// ACTIVE_LOW=1. One frame is 32 clocks. k counts rising edges since reset
// release, so frame phase p = (k-1) mod 32 at each falling-edge sample.
// -----------------------------------------------------------------------------
module tb_seven_segment_scanner;

   logic        CLK;
   logic        RST_X;
   logic [15:0] VALUE;
   logic [3:0]  DP;
   logic [3:0]  BLANK;
   logic        LOAD;
   logic        PENDING;
   logic [3:0]  LED_AN;
   logic [6:0]  LED_SEG;
   logic        LED_DP;

   int checks;
   int errors;
   int k;

   // observations of one frame, converted to active-high
   logic [3:0]  an_obs  [32];
   logic [6:0]  seg_obs [32];
   logic        dp_obs  [32];
   logic        pend_obs;

   seven_segment_scanner #(
      .DIGITS     (4),
      .DIV        (8),
      .GUARD      (2),
      .ACTIVE_LOW (1)
   ) dut (
      .CLK     (CLK),
      .RST_X   (RST_X),
      .VALUE   (VALUE),
      .DP      (DP),
      .BLANK   (BLANK),
      .LOAD    (LOAD),
      .PENDING (PENDING),
      .LED_AN  (LED_AN),
      .LED_SEG (LED_SEG),
      .LED_DP  (LED_DP)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK or negedge RST_X) begin
      if (!RST_X) k <= 0;
      else        k <= k + 1;
   end

   task automatic wait_phase(input int ph);
      @(negedge CLK);
      for (int n = 0; n < 40 && (k % 32) != ph; n++) @(negedge CLK);
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
      VALUE = v;
      DP    = d;
      BLANK = b;
      LOAD  = 1'b1;
      @(negedge CLK);
      LOAD  = 1'b0;
   endtask

   // Records one full frame starting at phase 0 (idx 0, prescaler 0).
   task automatic capture_frame();
      wait_phase(1);
      pend_obs = PENDING;
      for (int p = 0; p < 32; p++) begin
         an_obs[p]  = ~LED_AN;
         seg_obs[p] = ~LED_SEG;
         dp_obs[p]  = ~LED_DP;
         if (p < 31) @(negedge CLK);
      end
   endtask

   task automatic test_reset();
      RST_X = 1'b0;
      repeat (10) @(negedge CLK);
      checks++;
      if (LED_AN !== 4'b1111) begin errors++; $display("FAIL reset_an got %b want 1111", LED_AN); end
      checks++;
      if (LED_SEG !== 7'h7F) begin errors++; $display("FAIL reset_seg got %h want 7f", LED_SEG); end
      checks++;
      if (LED_DP !== 1'b1) begin errors++; $display("FAIL reset_dp got %b want 1", LED_DP); end
      checks++;
      if (PENDING !== 1'b0) begin errors++; $display("FAIL reset_pending got %b want 0", PENDING); end
      RST_X = 1'b1;
      capture_frame();
      for (int p = 0; p < 32; p++) begin
         checks++;
         if (an_obs[p] !== 4'b0 || seg_obs[p] !== 7'h0 || dp_obs[p] !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset p=%0d an=%b seg=%h dp=%b want all inactive", p, an_obs[p], seg_obs[p], dp_obs[p]);
         end
      end
   endtask

   task automatic test_scan();
      logic [6:0] exp_seg [4];
      logic [3:0] exp_an;
      int         on_cnt  [4];
      exp_seg = '{7'h66, 7'h4F, 7'h5B, 7'h06};   // digits 0..3 show 4,3,2,1
      on_cnt  = '{0, 0, 0, 0};
      wait_phase(5);
      do_load(16'h1234, 4'b0000, 4'b0000);
      checks++;
      if (PENDING !== 1'b1) begin errors++; $display("FAIL scan_pending_set got %b want 1", PENDING); end
      capture_frame();
      checks++;
      if (pend_obs !== 1'b0) begin errors++; $display("FAIL scan_pending_clear got %b want 0", pend_obs); end
      for (int p = 0; p < 32; p++) begin
         exp_an = ((p % 8) >= 2) ? (4'b0001 << (p / 8)) : 4'b0000;
         checks++;
         if (an_obs[p] !== exp_an) begin errors++; $display("FAIL scan_an p=%0d got %b want %b", p, an_obs[p], exp_an); end
         for (int d = 0; d < 4; d++) if (an_obs[p][d]) on_cnt[d]++;
         if (exp_an != 4'b0) begin
            checks++;
            if (seg_obs[p] !== exp_seg[p / 8] || dp_obs[p] !== 1'b0) begin
               errors++;
               $display("FAIL scan_seg p=%0d got %h/%b want %h/0", p, seg_obs[p], dp_obs[p], exp_seg[p / 8]);
            end
         end
      end
      for (int d = 0; d < 4; d++) begin
         checks++;
         if (on_cnt[d] != 6) begin errors++; $display("FAIL scan_on_cycles digit=%0d got %0d want 6", d, on_cnt[d]); end
      end
   endtask

   task automatic test_tear_free();
      logic [3:0] exp_an;
      wait_phase(10);
      do_load(16'hAAAA, 4'b0000, 4'b0000);
      wait_phase(14);
      do_load(16'h5555, 4'b0000, 4'b0000);
      checks++;
      if (PENDING !== 1'b1) begin errors++; $display("FAIL tear_pending got %b want 1", PENDING); end
      // rest of the current frame must still show 1234, never A
      for (int n = 0; n < 16; n++) begin
         checks++;
         if (~LED_AN != 4'b0 && ~LED_SEG === 7'h77) begin
            errors++; $display("FAIL tear_aaaa_seen n=%0d seg=%h", n, ~LED_SEG);
         end
         @(negedge CLK);
      end
      capture_frame();
      for (int p = 0; p < 32; p++) begin
         exp_an = ((p % 8) >= 2) ? (4'b0001 << (p / 8)) : 4'b0000;
         checks++;
         if (an_obs[p] !== exp_an) begin errors++; $display("FAIL tear_an p=%0d got %b want %b", p, an_obs[p], exp_an); end
         if (exp_an != 4'b0) begin
            checks++;
            if (seg_obs[p] !== 7'h6D) begin errors++; $display("FAIL tear_seg p=%0d got %h want 6d", p, seg_obs[p]); end
         end
      end
   endtask

   task automatic test_blank_dp();
      logic [6:0] exp_seg [4];
      logic       exp_dp  [4];
      logic [3:0] exp_an;
      exp_seg = '{7'h7F, 7'h00, 7'h7F, 7'h7F};
      exp_dp  = '{1'b1, 1'b0, 1'b1, 1'b0};
      wait_phase(3);
      do_load(16'h8888, 4'b0101, 4'b0010);
      capture_frame();
      for (int p = 0; p < 32; p++) begin
         exp_an = ((p % 8) >= 2) ? (4'b0001 << (p / 8)) : 4'b0000;
         checks++;
         if (an_obs[p] !== exp_an) begin errors++; $display("FAIL blank_an p=%0d got %b want %b", p, an_obs[p], exp_an); end
         if (exp_an != 4'b0) begin
            checks++;
            if (seg_obs[p] !== exp_seg[p / 8] || dp_obs[p] !== exp_dp[p / 8]) begin
               errors++;
               $display("FAIL blank_seg_dp p=%0d got %h/%b want %h/%b", p, seg_obs[p], dp_obs[p], exp_seg[p / 8], exp_dp[p / 8]);
            end
         end
      end
   endtask

   task automatic test_collision();
      wait_phase(5);
      do_load(16'h1111, 4'b0000, 4'b0000);
      wait_phase(31);
      do_load(16'h2222, 4'b0000, 4'b0000);   // captured on the transfer edge
      checks++;
      if (PENDING !== 1'b1) begin errors++; $display("FAIL coll_pending_after got %b want 1", PENDING); end
      capture_frame();
      checks++;
      if (pend_obs !== 1'b1) begin errors++; $display("FAIL coll_pending_frame1 got %b want 1", pend_obs); end
      for (int p = 0; p < 32; p++) begin
         if ((p % 8) >= 2) begin
            checks++;
            if (seg_obs[p] !== 7'h06) begin errors++; $display("FAIL coll_frame1_seg p=%0d got %h want 06", p, seg_obs[p]); end
         end
      end
      capture_frame();
      checks++;
      if (pend_obs !== 1'b0) begin errors++; $display("FAIL coll_pending_frame2 got %b want 0", pend_obs); end
      for (int p = 0; p < 32; p++) begin
         if ((p % 8) >= 2) begin
            checks++;
            if (seg_obs[p] !== 7'h5B) begin errors++; $display("FAIL coll_frame2_seg p=%0d got %h want 5b", p, seg_obs[p]); end
         end
      end
   endtask

   task automatic test_mid_reset();
      wait_phase(5);
      do_load(16'h3333, 4'b1111, 4'b0000);
      checks++;
      if (PENDING !== 1'b1 || LED_AN !== 4'b1110) begin
         errors++; $display("FAIL midrst_before pend=%b an=%b want 1/1110", PENDING, LED_AN);
      end
      #2 RST_X = 1'b0;
      #1;
      checks++;
      if (LED_AN !== 4'b1111 || LED_SEG !== 7'h7F || LED_DP !== 1'b1 || PENDING !== 1'b0) begin
         errors++;
         $display("FAIL midrst_async an=%b seg=%h dp=%b pend=%b want 1111/7f/1/0", LED_AN, LED_SEG, LED_DP, PENDING);
      end
      repeat (3) @(negedge CLK);
      RST_X = 1'b1;
      for (int f = 0; f < 2; f++) begin
         capture_frame();
         checks++;
         if (pend_obs !== 1'b0) begin errors++; $display("FAIL midrst_pending f=%0d got %b want 0", f, pend_obs); end
         for (int p = 0; p < 32; p++) begin
            checks++;
            if (an_obs[p] !== 4'b0 || seg_obs[p] !== 7'h0 || dp_obs[p] !== 1'b0) begin
               errors++;
               $display("FAIL midrst_dark f=%0d p=%0d an=%b seg=%h dp=%b", f, p, an_obs[p], seg_obs[p], dp_obs[p]);
            end
         end
      end
      wait_phase(5);
      do_load(16'h4444, 4'b0000, 4'b0000);
      capture_frame();
      for (int p = 0; p < 32; p++) begin
         if ((p % 8) >= 2) begin
            checks++;
            if (an_obs[p] !== (4'b0001 << (p / 8)) || seg_obs[p] !== 7'h66) begin
               errors++;
               $display("FAIL midrst_reload p=%0d an=%b seg=%h want %b/66", p, an_obs[p], seg_obs[p], 4'b0001 << (p / 8));
            end
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      CLK    = 1'b0;
      RST_X  = 1'b0;
      VALUE  = '0;
      DP     = '0;
      BLANK  = '0;
      LOAD   = 1'b0;
      test_reset();
      test_scan();
      test_tear_free();
      test_blank_dp();
      test_collision();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
